jellyvl_etherneco_func_dispatcher: RTL and testbench
====================================================

Name: jellyvl_etherneco_func_dispatcher

Overview:
- Per-loop payload dispatcher that sits between one jellyvl_etherneco_packet_rx instance and up to FUNC_NUM function blocks (synctimer, GPIO, register access, ...).
- Selects one function channel per packet by rx_type, forwards header events and payload to that channel only, and muxes that channel's replace stream back to the packet_rx.
- Replaces the single hard-wired function binding of the current slave node.
- Also keeps per-channel packet/error statistics.

Parameters:
- FUNC_NUM, 4, number of function channels (1..16).
- FUNC_TYPES, {8'h04,8'h03,8'h02,8'h01}, packed FUNC_NUM*8 bits; channel i matches rx_type == FUNC_TYPES[i*8+:8].
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- func_enable  in  FUNC_NUM  per-channel enable mask; sampled at rx_start.
- rx_start, rx_end, rx_error  in  1 each  packet event pulses from packet_rx.
- rx_length  in  16  packet length.
- rx_type  in  8  packet type.
- rx_node  in  8  packet node.
- s_first, s_last, s_valid  in  1 each  payload stream from packet_rx.
- s_pos  in  16  payload position.
- s_data  in  8  payload data.
- m_data  out  8  replace data to packet_rx.
- m_valid  out  1  replace valid to packet_rx.
- f_rx_start, f_rx_end, f_rx_error  out  FUNC_NUM each  per-channel event pulses.
- f_rx_length  out  16  shared header length.
- f_rx_type  out  8  shared header type.
- f_rx_node  out  8  shared header node.
- f_first, f_last, f_valid  out  FUNC_NUM each  per-channel payload qualifiers.
- f_pos  out  16  shared payload position.
- f_data  out  8  shared payload data.
- f_rep_data  in  FUNC_NUM*8  per-channel replace data.
- f_rep_valid  in  FUNC_NUM  per-channel replace valid.
- stat_pkt  out  FUNC_NUM*CNT_WIDTH  per-channel completed-packet counters.
- stat_err  out  FUNC_NUM*CNT_WIDTH  per-channel error/abort counters.
- stat_unmatched  out  CNT_WIDTH  packets with no enabled match.
- busy  out  1  high while in ACTIVE.

Behaviour:
- Reset (reset==0, asynchronous): all outputs 0, state IDLE, sel=0, all counters 0.
- Forward path latency: exactly 1 clk.
  - All f_* header, event and payload outputs are registered copies of the inputs.
  - Per-channel bits are gated by the one-hot selection; shared buses are always driven.
  - Host packet_rx uses REPLACE_DELAY = 1 + function replace latency.
- Return path: combinational mux of f_rep_data/f_rep_valid[sel] while ACTIVE; m_valid=0 otherwise.
- Match at rx_start: sel = lowest i with FUNC_TYPES[i]==rx_type and func_enable[i]. Multiple matches resolve to the lowest index.
- States:
  - IDLE:
    - rx_start with match: pulse f_rx_start[sel] next cycle, go to ACTIVE.
    - rx_start without match: stat_unmatched++, go to DROP.
  - ACTIVE:
    - payload forwarded to sel.
    - rx_end: pulse f_rx_end[sel], stat_pkt[sel]++, go to IDLE.
    - rx_error: pulse f_rx_error[sel], stat_err[sel]++, go to IDLE.
  - DROP: payload discarded, m_valid=0; rx_end or rx_error returns to IDLE.
- rx_error has priority over rx_end in the same cycle.
- rx_start while ACTIVE (lost end):
  - abort current channel: pulse f_rx_error[old], stat_err[old]++.
  - same cycle, re-evaluate the match and start the new packet; the new f_rx_start follows one cycle later.
- rx_start while DROP: treated as from IDLE.
- rx_start and rx_end in the same cycle: end applies to the current packet first, then the start is processed.
- func_enable changes mid-packet have no effect until the next rx_start.
- s_valid outside ACTIVE is ignored.
- Counters saturate at all-ones; no wrap.
- Reset mid-packet: immediate IDLE. No f_rx_error is emitted; functions share the same reset.

Decomposition:
- Package jellyvl_etherneco_pkg: state enum (IDLE/ACTIVE/DROP) and packet-type constants for synctimer, GPIO and register functions.
- Sub-module jellyvl_etherneco_sat_counter (CNT_WIDTH, inc, clear) instantiated 2*FUNC_NUM+1 times.

Test Plan:
- Type 8'h02, enable=4'hF, 10-byte payload -> only f_valid[1] asserted, 10 beats 1 clk late; f_rx_end[1] pulses; stat_pkt[1]=1; others 0.
- Type 8'h02 with enable=4'b1101 -> DROP, no f_* pulses, m_valid=0 throughout, stat_unmatched=1.
- Channel 2 drives f_rep_valid=1, f_rep_data=8'hA5 during its packet -> m_valid=1, m_data=8'hA5 in same cycle. Channels 0/1/3 driving valid are never propagated.
- rx_start (type 01) at beat 4 of an ACTIVE type-03 packet -> f_rx_error[2] pulses, stat_err[2]=1, f_rx_start[0] next cycle.
- rx_error and rx_end together -> f_rx_error only, stat_err++, stat_pkt unchanged.
- CNT_WIDTH=4, 17 good packets on channel 0 -> stat_pkt[0] holds 4'hF.
- Assert reset low mid-payload -> all outputs 0 asynchronously. Next packet after release dispatches normally.

Source files
------------

// File: rtl/jellyvl_etherneco_pkg.sv
// Shared types and constants for the etherneco slave function dispatcher.
package jellyvl_etherneco_pkg;

    // Packet dispatch state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    // Packet types of the standard function blocks
    localparam logic [7:0] TYPE_SYNCTIMER = 8'h01;
    localparam logic [7:0] TYPE_GPIO      = 8'h02;
    localparam logic [7:0] TYPE_REGACC    = 8'h03;

endpackage

// File: rtl/jellyvl_etherneco_sat_counter.sv
// Saturating up-counter used for the per-channel packet statistics.
module jellyvl_etherneco_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_r;

    // Count up on inc, hold at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (inc && (count_r != '1)) begin
            count_r <= count_r + CNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/jellyvl_etherneco_func_dispatcher.sv
// Routes each received packet to one function channel selected by its type,
// forwards events/payload one clock late, muxes the replace stream back and
// keeps per-channel statistics.
module jellyvl_etherneco_func_dispatcher
    import jellyvl_etherneco_pkg::*;
#(
    parameter int                       FUNC_NUM   = 4,
    parameter logic [FUNC_NUM*8-1:0]    FUNC_TYPES = {8'h04, 8'h03, 8'h02, 8'h01},
    parameter int                       CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FUNC_NUM-1:0]           func_enable,

    input  logic                          rx_start,
    input  logic                          rx_end,
    input  logic                          rx_error,
    input  logic [15:0]                   rx_length,
    input  logic [7:0]                    rx_type,
    input  logic [7:0]                    rx_node,

    input  logic                          s_first,
    input  logic                          s_last,
    input  logic [15:0]                   s_pos,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic [7:0]                    m_data,
    output logic                          m_valid,

    output logic [FUNC_NUM-1:0]           f_rx_start,
    output logic [FUNC_NUM-1:0]           f_rx_end,
    output logic [FUNC_NUM-1:0]           f_rx_error,
    output logic [15:0]                   f_rx_length,
    output logic [7:0]                    f_rx_type,
    output logic [7:0]                    f_rx_node,
    output logic [FUNC_NUM-1:0]           f_first,
    output logic [FUNC_NUM-1:0]           f_last,
    output logic [15:0]                   f_pos,
    output logic [7:0]                    f_data,
    output logic [FUNC_NUM-1:0]           f_valid,
    input  logic [FUNC_NUM*8-1:0]         f_rep_data,
    input  logic [FUNC_NUM-1:0]           f_rep_valid,

    output logic [FUNC_NUM*CNT_WIDTH-1:0] stat_pkt,
    output logic [FUNC_NUM*CNT_WIDTH-1:0] stat_err,
    output logic [CNT_WIDTH-1:0]          stat_unmatched,
    output logic                          busy
);

    localparam int SEL_W = (FUNC_NUM > 1) ? $clog2(FUNC_NUM) : 1;

    state_t                state_r;
    state_t                state_s;
    logic [SEL_W-1:0]      sel_r;
    logic [SEL_W-1:0]      sel_s;

    logic                  match_s;
    logic [SEL_W-1:0]      match_idx_s;
    logic [FUNC_NUM-1:0]   match_oh_s;
    logic [FUNC_NUM-1:0]   cur_oh_s;
    logic                  active_s;

    logic                  end_cur_s;
    logic                  err_cur_s;
    logic                  start_new_s;
    logic                  unmatched_s;

    logic [7:0]            m_data_s;
    logic                  m_valid_s;

    assign active_s = (state_r == ST_ACTIVE);

    // Lowest-index enabled channel whose type matches wins (scan high to low)
    always_comb begin
        match_s     = 1'b0;
        match_idx_s = '0;
        for (int i = FUNC_NUM - 1; i >= 0; i--) begin
            if (func_enable[i] && (FUNC_TYPES[i*8 +: 8] == rx_type)) begin
                match_s     = 1'b1;
                match_idx_s = SEL_W'(i);
            end else begin
                match_s     = match_s;
            end
        end
    end

    // One-hot decode of the current and the newly matched channel
    always_comb begin
        cur_oh_s   = '0;
        match_oh_s = '0;
        for (int i = 0; i < FUNC_NUM; i++) begin
            cur_oh_s[i]   = (sel_r == SEL_W'(i));
            match_oh_s[i] = match_s && (match_idx_s == SEL_W'(i));
        end
    end

    // Next state: close the current packet first, then handle a new start
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        end_cur_s   = 1'b0;
        err_cur_s   = 1'b0;
        start_new_s = 1'b0;
        unmatched_s = 1'b0;

        case (state_r)
            ST_ACTIVE: begin
                if (rx_error) begin
                    err_cur_s = 1'b1;
                    state_s   = ST_IDLE;
                end else if (rx_end) begin
                    end_cur_s = 1'b1;
                    state_s   = ST_IDLE;
                end else if (rx_start) begin
                    // start without end: the old packet is aborted
                    err_cur_s = 1'b1;
                end else begin
                    state_s   = state_r;
                end
            end
            ST_DROP: begin
                if (rx_error || rx_end) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_IDLE: begin
                state_s = state_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (rx_start) begin
            if (match_s) begin
                state_s     = ST_ACTIVE;
                sel_s       = match_idx_s;
                start_new_s = 1'b1;
            end else begin
                state_s     = ST_DROP;
                unmatched_s = 1'b1;
            end
        end else begin
            sel_s = sel_s;
        end
    end

    // State and selected channel registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
        end else begin
            state_r <= state_s;
            sel_r   <= sel_s;
        end
    end

    // Forward path: one-clock registered copies, per-channel bits gated by selection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_rx_start  <= '0;
            f_rx_end    <= '0;
            f_rx_error  <= '0;
            f_rx_length <= 16'h0000;
            f_rx_type   <= 8'h00;
            f_rx_node   <= 8'h00;
            f_first     <= '0;
            f_last      <= '0;
            f_pos       <= 16'h0000;
            f_data      <= 8'h00;
            f_valid     <= '0;
        end else begin
            f_rx_start  <= start_new_s ? match_oh_s : '0;
            f_rx_end    <= end_cur_s   ? cur_oh_s   : '0;
            f_rx_error  <= err_cur_s   ? cur_oh_s   : '0;
            f_rx_length <= rx_length;
            f_rx_type   <= rx_type;
            f_rx_node   <= rx_node;
            f_first     <= (active_s && s_first) ? cur_oh_s : '0;
            f_last      <= (active_s && s_last)  ? cur_oh_s : '0;
            f_pos       <= s_pos;
            f_data      <= s_data;
            f_valid     <= (active_s && s_valid) ? cur_oh_s : '0;
        end
    end

    // Return path: combinational mux of the selected channel while ACTIVE
    always_comb begin
        m_data_s  = 8'h00;
        m_valid_s = 1'b0;
        for (int i = 0; i < FUNC_NUM; i++) begin
            if (active_s && cur_oh_s[i]) begin
                m_data_s  = f_rep_data[i*8 +: 8];
                m_valid_s = f_rep_valid[i];
            end else begin
                m_data_s  = m_data_s;
            end
        end
    end

    assign m_data  = m_data_s;
    assign m_valid = m_valid_s;
    assign busy    = active_s;

    // Per-channel statistics
    for (genvar g = 0; g < FUNC_NUM; g++) begin : g_stat
        jellyvl_etherneco_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt_pkt (
            .clk   (clk),
            .rst_n (reset),
            .clear (1'b0),
            .inc   (end_cur_s && cur_oh_s[g]),
            .count (stat_pkt[g*CNT_WIDTH +: CNT_WIDTH])
        );

        jellyvl_etherneco_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt_err (
            .clk   (clk),
            .rst_n (reset),
            .clear (1'b0),
            .inc   (err_cur_s && cur_oh_s[g]),
            .count (stat_err[g*CNT_WIDTH +: CNT_WIDTH])
        );
    end

    jellyvl_etherneco_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt_unmatched (
        .clk   (clk),
        .rst_n (reset),
        .clear (1'b0),
        .inc   (unmatched_s),
        .count (stat_unmatched)
    );

endmodule

// File: tb/tb_jellyvl_etherneco_func_dispatcher.sv
// Directed testbench for jellyvl_etherneco_func_dispatcher. A second instance
// with 4-bit counters shares all inputs to observe counter saturation.
module tb_jellyvl_etherneco_func_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  func_enable;
    logic        rx_start, rx_end, rx_error;
    logic [15:0] rx_length;
    logic [7:0]  rx_type, rx_node;
    logic        s_first, s_last, s_valid;
    logic [15:0] s_pos;
    logic [7:0]  s_data;
    logic [31:0] f_rep_data;
    logic [3:0]  f_rep_valid;

    logic [7:0]  m_data;
    logic        m_valid;
    logic [3:0]  f_rx_start, f_rx_end, f_rx_error, f_first, f_last, f_valid;
    logic [15:0] f_rx_length, f_pos;
    logic [7:0]  f_rx_type, f_rx_node, f_data;
    logic [63:0] stat_pkt, stat_err;
    logic [15:0] stat_unmatched;
    logic        busy;

    logic [7:0]  m_data4;
    logic        m_valid4;
    logic [3:0]  f_rx_start4, f_rx_end4, f_rx_error4, f_first4, f_last4, f_valid4;
    logic [15:0] f_rx_length4, f_pos4;
    logic [7:0]  f_rx_type4, f_rx_node4, f_data4;
    logic [15:0] stat_pkt4, stat_err4;
    logic [3:0]  stat_unmatched4;
    logic        busy4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jellyvl_etherneco_func_dispatcher u_dut (
        .clk(clk), .reset(reset), .func_enable(func_enable),
        .rx_start(rx_start), .rx_end(rx_end), .rx_error(rx_error),
        .rx_length(rx_length), .rx_type(rx_type), .rx_node(rx_node),
        .s_first(s_first), .s_last(s_last), .s_pos(s_pos), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data), .m_valid(m_valid),
        .f_rx_start(f_rx_start), .f_rx_end(f_rx_end), .f_rx_error(f_rx_error),
        .f_rx_length(f_rx_length), .f_rx_type(f_rx_type), .f_rx_node(f_rx_node),
        .f_first(f_first), .f_last(f_last), .f_pos(f_pos), .f_data(f_data), .f_valid(f_valid),
        .f_rep_data(f_rep_data), .f_rep_valid(f_rep_valid),
        .stat_pkt(stat_pkt), .stat_err(stat_err), .stat_unmatched(stat_unmatched), .busy(busy)
    );

    jellyvl_etherneco_func_dispatcher #(.CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .func_enable(func_enable),
        .rx_start(rx_start), .rx_end(rx_end), .rx_error(rx_error),
        .rx_length(rx_length), .rx_type(rx_type), .rx_node(rx_node),
        .s_first(s_first), .s_last(s_last), .s_pos(s_pos), .s_data(s_data), .s_valid(s_valid),
        .m_data(m_data4), .m_valid(m_valid4),
        .f_rx_start(f_rx_start4), .f_rx_end(f_rx_end4), .f_rx_error(f_rx_error4),
        .f_rx_length(f_rx_length4), .f_rx_type(f_rx_type4), .f_rx_node(f_rx_node4),
        .f_first(f_first4), .f_last(f_last4), .f_pos(f_pos4), .f_data(f_data4), .f_valid(f_valid4),
        .f_rep_data(f_rep_data), .f_rep_valid(f_rep_valid),
        .stat_pkt(stat_pkt4), .stat_err(stat_err4), .stat_unmatched(stat_unmatched4), .busy(busy4)
    );

    // Count one comparison and report a mismatch
    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rx_start = 1'b0; rx_end = 1'b0; rx_error = 1'b0;
        s_valid  = 1'b0; s_first = 1'b0; s_last = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        func_enable = 4'hF;
        rx_length   = 16'd0;
        rx_type     = 8'h00;
        rx_node     = 8'h00;
        s_pos       = 16'd0;
        s_data      = 8'h00;
        f_rep_data  = 32'h0;
        f_rep_valid = 4'h0;
        clear_inputs();
        step();
        step();

        // Reset state
        check_val("rst_f_valid", f_valid, 4'h0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_m_valid", m_valid, 1'b0);
        check_val("rst_stat_pkt", stat_pkt, 64'h0);
        check_val("rst_unmatched", stat_unmatched, 16'h0);
        reset = 1'b1;
        step();

        // Type 02 -> channel 1, 10-byte payload
        rx_start = 1'b1; rx_type = 8'h02; rx_length = 16'd10; rx_node = 8'h07;
        step();
        rx_start = 1'b0;
        check_val("t1_start", f_rx_start, 4'b0010);
        check_val("t1_hdr_len", f_rx_length, 16'd10);
        check_val("t1_hdr_node", f_rx_node, 8'h07);
        check_val("t1_busy", busy, 1'b1);
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_data = 8'(8'h10 + k); s_pos = 16'(k);
            s_first = (k == 0); s_last = (k == 9);
            step();
            check_val("t1_valid", f_valid, 4'b0010);
            check_val("t1_data", f_data, 8'(8'h10 + k));
            check_val("t1_first", f_first, (k == 0) ? 4'b0010 : 4'b0000);
            check_val("t1_last", f_last, (k == 9) ? 4'b0010 : 4'b0000);
        end
        clear_inputs();
        rx_end = 1'b1;
        step();
        rx_end = 1'b0;
        check_val("t1_end", f_rx_end, 4'b0010);
        check_val("t1_valid_off", f_valid, 4'b0000);
        check_val("t1_busy_off", busy, 1'b0);
        check_val("t1_stat_pkt", stat_pkt, {16'd0, 16'd0, 16'd1, 16'd0});

        // Type 02 with channel 1 disabled -> DROP
        func_enable = 4'b1101;
        rx_start = 1'b1; rx_type = 8'h02;
        step();
        rx_start = 1'b0;
        func_enable = 4'hF;
        f_rep_valid = 4'hF;
        check_val("t2_start", f_rx_start, 4'b0000);
        check_val("t2_busy", busy, 1'b0);
        check_val("t2_unmatched", stat_unmatched, 16'd1);
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 8'(k);
            #1;
            check_val("t2_m_valid", m_valid, 1'b0);
            step();
            check_val("t2_valid", f_valid, 4'b0000);
        end
        clear_inputs();
        rx_end = 1'b1;
        step();
        rx_end = 1'b0;
        f_rep_valid = 4'h0;
        check_val("t2_end", f_rx_end, 4'b0000);
        check_val("t2_stat_pkt", stat_pkt, {16'd0, 16'd0, 16'd1, 16'd0});

        // Type 03 -> channel 2, replace mux, then aborted by a type 01 start
        rx_start = 1'b1; rx_type = 8'h03;
        step();
        rx_start = 1'b0;
        check_val("t3_start", f_rx_start, 4'b0100);
        f_rep_data = {8'h33, 8'hA5, 8'h11, 8'h22};
        f_rep_valid = 4'b0100;
        #1;
        check_val("t3_m_valid", m_valid, 1'b1);
        check_val("t3_m_data", m_data, 8'hA5);
        f_rep_valid = 4'b1011;
        #1;
        check_val("t3_m_valid_other", m_valid, 1'b0);
        f_rep_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1; s_data = 8'(8'h30 + k);
            step();
            check_val("t3_valid", f_valid, 4'b0100);
        end
        clear_inputs();
        rx_start = 1'b1; rx_type = 8'h01;
        step();
        rx_start = 1'b0;
        check_val("t4_abort_err", f_rx_error, 4'b0100);
        check_val("t4_new_start", f_rx_start, 4'b0001);
        check_val("t4_stat_err2", stat_err[47:32], 16'd1);
        check_val("t4_busy", busy, 1'b1);
        rx_end = 1'b1;
        step();
        rx_end = 1'b0;
        check_val("t4_end", f_rx_end, 4'b0001);
        check_val("t4_err_none", f_rx_error, 4'b0000);
        check_val("t4_stat_pkt0", stat_pkt[15:0], 16'd1);

        // Type 04 -> channel 3, rx_error and rx_end together
        rx_start = 1'b1; rx_type = 8'h04;
        step();
        rx_start = 1'b0;
        check_val("t5_start", f_rx_start, 4'b1000);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        rx_error = 1'b1; rx_end = 1'b1;
        step();
        clear_inputs();
        check_val("t5_err", f_rx_error, 4'b1000);
        check_val("t5_end", f_rx_end, 4'b0000);
        check_val("t5_stat_err3", stat_err[63:48], 16'd1);
        check_val("t5_stat_pkt3", stat_pkt[63:48], 16'd0);

        // Enable mask change mid-packet has no effect on the current packet
        rx_start = 1'b1; rx_type = 8'h01;
        step();
        rx_start = 1'b0;
        func_enable = 4'h0;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check_val("t6_valid", f_valid, 4'b0001);
        rx_end = 1'b1;
        step();
        rx_end = 1'b0;
        func_enable = 4'hF;
        check_val("t6_end", f_rx_end, 4'b0001);
        check_val("t6_stat_pkt0", stat_pkt[15:0], 16'd2);

        // Reset asserted mid-payload
        rx_start = 1'b1; rx_type = 8'h02;
        step();
        rx_start = 1'b0;
        f_rep_valid = 4'b0010;
        s_valid = 1'b1;
        step();
        check_val("t7_valid_pre", f_valid, 4'b0010);
        check_val("t7_m_valid_pre", m_valid, 1'b1);
        reset = 1'b0;
        #1;
        check_val("t7_valid_rst", f_valid, 4'b0000);
        check_val("t7_busy_rst", busy, 1'b0);
        check_val("t7_m_valid_rst", m_valid, 1'b0);
        check_val("t7_stat_pkt_rst", stat_pkt, 64'h0);
        check_val("t7_stat_err_rst", stat_err, 64'h0);
        clear_inputs();
        f_rep_valid = 4'h0;
        step();
        reset = 1'b1;
        step();
        rx_start = 1'b1; rx_type = 8'h02;
        step();
        rx_start = 1'b0;
        check_val("t7_start", f_rx_start, 4'b0010);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check_val("t7_valid", f_valid, 4'b0010);
        rx_end = 1'b1;
        step();
        rx_end = 1'b0;
        check_val("t7_end", f_rx_end, 4'b0010);
        check_val("t7_stat_pkt1", stat_pkt[31:16], 16'd1);

        // 17 back-to-back channel-0 packets (end and next start share a cycle)
        rx_start = 1'b1; rx_type = 8'h01;
        step();
        rx_start = 1'b0;
        for (int k = 0; k < 17; k++) begin
            s_valid = 1'b1; s_first = 1'b1; s_last = 1'b1; s_data = 8'(k);
            step();
            clear_inputs();
            rx_end = 1'b1;
            rx_start = (k < 16);
            step();
            clear_inputs();
            check_val("t8_end", f_rx_end, 4'b0001);
            check_val("t8_no_err", f_rx_error, 4'b0000);
            check_val("t8_restart", f_rx_start, (k < 16) ? 4'b0001 : 4'b0000);
            if (k == 13) begin
                check_val("t8_sat4_14", stat_pkt4[3:0], 4'hE);
                check_val("t8_pkt0_14", stat_pkt[15:0], 16'd14);
            end
        end
        check_val("t8_sat4_17", stat_pkt4, 16'h001F);
        check_val("t8_pkt0_17", stat_pkt[15:0], 16'd17);
        check_val("t8_busy", busy, 1'b0);
        check_val("t8_err_total", stat_err, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
